// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: sequential instruction prefetcher with a DEPTH-entry FIFO.
// One bus read outstanding at a time; a flush redirects fetch and discards
// buffered entries plus any response still in flight.
module inst_fetch_buf #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    input  logic             flush,
    input  logic [29:0]      flush_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [29:0]      inst_pc,
    output logic [LVL_W-1:0] fifo_level,
    output logic             i_read_req,
    output logic             i_read_w,
    output logic             i_read_hw,
    output logic [31:0]      i_read_adr,
    input  logic             i_read_valid,
    input  logic [31:0]      i_read_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic [29:0]      fetch_pc;
    logic [29:0]      req_pc;
    logic             drop;

    logic [31:0]      mem_inst [DEPTH];
    logic [29:0]      mem_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] count;

    logic             push;
    logic             pop;

    // A response is kept only if it belongs to the current fetch stream.
    assign push = (state == WAIT) && i_read_valid && !drop && !flush;
    assign pop  = inst_valid && inst_ready && !flush;

    // Fetch FSM: one request pulse, then wait for its data; flush retargets fetch_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= '0;
            drop       <= 1'b0;
            i_read_req <= 1'b0;
        end else begin
            i_read_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        fetch_pc <= flush_pc;
                    end else if (fetch_en && (count < FULL_LVL)) begin
                        state      <= REQ;
                        i_read_req <= 1'b1;
                    end
                end
                REQ: begin
                    // The request already went out, so its response must be absorbed.
                    state <= WAIT;
                    if (flush) begin
                        fetch_pc <= flush_pc;
                        drop     <= 1'b1;
                    end else begin
                        fetch_pc <= fetch_pc + 30'd1;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        fetch_pc <= flush_pc;
                    end
                    if (i_read_valid) begin
                        // A response coinciding with flush is consumed here, not later.
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture the address of the request being issued for tagging its response.
    always_ff @(posedge clk) begin
        if (state == REQ) begin
            req_pc <= fetch_pc;
        end
    end

    // FIFO bookkeeping: pointers and occupancy; flush empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // FIFO storage; contents only matter where count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= i_read_data;
            mem_pc[wr_ptr]   <= req_pc;
        end
    end

    assign inst_valid = (count != '0);
    assign fifo_level = count;
    assign inst       = inst_valid ? mem_inst[rd_ptr] : 32'd0;
    assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 30'd0;

    // In REQ fetch_pc still equals the address being requested.
    assign i_read_adr = {((state == WAIT) ? req_pc : fetch_pc), 2'b00};
    assign i_read_w   = 1'b1;
    assign i_read_hw  = 1'b0;

endmodule
